// File: rtl/arb_client_if.sv
// Command, arbiter and shared-bus signals of one arb_client slot.
// master: the client itself; slave: the command source / arbiter / bus side.
interface arb_client_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [LEN_W-1:0]  cmd_len;
    logic              req;
    logic              grant;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              bus_last;

    modport master (
        input  cmd_valid, cmd_data, cmd_len, grant,
        output cmd_ready, req, bus_valid, bus_data, bus_last
    );

    modport slave (
        output cmd_valid, cmd_data, cmd_len, grant,
        input  cmd_ready, req, bus_valid, bus_data, bus_last
    );
endinterface

// File: rtl/arb_client.sv
// Round-robin arbiter requester: buffers commands, requests a slot, bursts beats.
// Optional request timeout enabled by defining ARB_CLIENT_TIMEOUT_EN.
module arb_client #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    arb_client_if.master cif,
    output logic         busy,
    output logic         spurious_grant,
    output logic         timeout_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [LEN_W-1:0]  len_mem  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [DATA_W-1:0] xfer_data_reg;
    logic [LEN_W-1:0]  xfer_len_reg;
    logic [LEN_W-1:0]  beat_reg;
    logic              spurious_reg;
    logic              push;
    logic              pop;
    logic              timeout_hit;

    assign cif.cmd_ready = (count_reg != FULL_CNT);
    assign push          = cif.cmd_valid && cif.cmd_ready;
    assign pop           = (state_reg == REQ) && cif.grant;

    // Head entry is read asynchronously so it can be latched on the grant edge.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= cif.cmd_data;
            len_mem[wr_ptr_reg]  <= cif.cmd_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef ARB_CLIENT_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_reg;
    logic              timeout_reg;

    // A grant in the same cycle as expiry takes priority over the timeout.
    assign timeout_hit = (state_reg == REQ) && !cif.grant &&
                         (wait_reg == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_hit;
            if (state_reg != REQ)
                wait_reg <= '0;
            else if (!timeout_hit)
                wait_reg <= wait_reg + WAIT_W'(1);
        end
    end

    assign timeout_err = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (count_reg != '0) state_next = REQ;
            REQ: begin
                if (cif.grant)
                    state_next = XFER;
                else if (timeout_hit)
                    state_next = GAP;
            end
            XFER: if (beat_reg == xfer_len_reg) state_next = GAP;
            GAP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            xfer_data_reg <= '0;
            xfer_len_reg  <= '0;
            beat_reg      <= '0;
            spurious_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                xfer_data_reg <= data_mem[rd_ptr_reg];
                xfer_len_reg  <= len_mem[rd_ptr_reg];
                beat_reg      <= '0;
            end else if (state_reg == XFER) begin
                beat_reg <= beat_reg + LEN_W'(1);
            end
            if (cif.grant && (state_reg != REQ))
                spurious_reg <= 1'b1;
        end
    end

    // Bus outputs are forced to zero outside XFER so GAP/IDLE show a quiet bus.
    assign cif.req        = (state_reg == REQ);
    assign cif.bus_valid  = (state_reg == XFER);
    assign cif.bus_data   = (state_reg == XFER) ? (xfer_data_reg + DATA_W'(beat_reg)) : '0;
    assign cif.bus_last   = (state_reg == XFER) && (beat_reg == xfer_len_reg);
    assign busy           = (state_reg != IDLE) || (count_reg != '0);
    assign spurious_grant = spurious_reg;
endmodule
